// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: IR/ALU status in, datapath enables and selects out.
// MC_PERF_EN adds the cycle_cnt/retire_cnt counter outputs.
interface mc_ctrl_if;
   logic [5:0] op;
   logic [5:0] func;
   logic       zero;
   logic       ir_we;
   logic       pc_we;
   logic       reg_we;
   logic       mem_we;
   logic [1:0] RegDst;
   logic [1:0] MemtoReg;
   logic [1:0] PCSrc;
   logic       ALUSrc;
   logic       ExtOp;
   logic [2:0] ALUOp;
   logic [2:0] state;
   logic       instr_done;
`ifdef MC_PERF_EN
   logic [31:0] cycle_cnt;
   logic [31:0] retire_cnt;

   modport master (
      input  op, func, zero,
      output ir_we, pc_we, reg_we, mem_we,
      output RegDst, MemtoReg, PCSrc,
      output ALUSrc, ExtOp, ALUOp,
      output state, instr_done,
      output cycle_cnt, retire_cnt
   );
   modport slave (
      output op, func, zero,
      input  ir_we, pc_we, reg_we, mem_we,
      input  RegDst, MemtoReg, PCSrc,
      input  ALUSrc, ExtOp, ALUOp,
      input  state, instr_done,
      input  cycle_cnt, retire_cnt
   );
`else
   modport master (
      input  op, func, zero,
      output ir_we, pc_we, reg_we, mem_we,
      output RegDst, MemtoReg, PCSrc,
      output ALUSrc, ExtOp, ALUOp,
      output state, instr_done
   );
   modport slave (
      output op, func, zero,
      input  ir_we, pc_we, reg_we, mem_we,
      input  RegDst, MemtoReg, PCSrc,
      input  ALUSrc, ExtOp, ALUOp,
      input  state, instr_done
   );
`endif
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS datapath.
// Define MC_PERF_EN to add cycle_cnt/retire_cnt performance counters.
module mc_ctrl #(
   parameter int FETCH_WAIT = 0
) (
   input logic       clk,
   input logic       reset,
   mc_ctrl_if.master bus
);
   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_t;

   typedef enum logic [3:0] {
      I_ADD, I_SUB, I_JR, I_ORI, I_LUI,
      I_LW, I_SW, I_BEQ, I_JAL, I_UNK
   } instr_t;

   localparam logic [2:0] WAIT_MAX = 3'(FETCH_WAIT);

   state_t     cur;
   state_t     nxt;
   logic [2:0] cnt;
   logic [2:0] cnt_nxt;
   instr_t     ins;
   logic       rtype;
   logic       last;
   logic       sel_on;
   logic       ir_we;
   logic       reg_we;
   logic       mem_we;

   // Classify the instruction held in IR.
   always_comb begin
      ins   = I_UNK;
      rtype = (bus.op == 6'b000000);
      unique case (1'b1)
         rtype && bus.func == 6'b100000: ins = I_ADD;
         rtype && bus.func == 6'b100010: ins = I_SUB;
         rtype && bus.func == 6'b001000: ins = I_JR;
         bus.op == 6'b001101:            ins = I_ORI;
         bus.op == 6'b001111:            ins = I_LUI;
         bus.op == 6'b100011:            ins = I_LW;
         bus.op == 6'b101011:            ins = I_SW;
         bus.op == 6'b000100:            ins = I_BEQ;
         bus.op == 6'b000011:            ins = I_JAL;
         default:                        ins = I_UNK;
      endcase
   end

   // State register and FETCH wait counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         cur <= FETCH;
         cnt <= 3'd0;
      end else begin
         cur <= nxt;
         cnt <= cnt_nxt;
      end
   end

   // Next state and write enables; nothing fires while reset is high.
   always_comb begin
      nxt     = FETCH;
      cnt_nxt = 3'd0;
      ir_we   = 1'b0;
      reg_we  = 1'b0;
      mem_we  = 1'b0;
      last    = 1'b0;
      sel_on  = 1'b0;
      case (cur)
         FETCH: begin
            if (cnt == WAIT_MAX) begin
               ir_we = 1'b1;
               nxt   = DECODE;
            end else begin
               nxt     = FETCH;
               cnt_nxt = cnt + 3'd1;
            end
         end
         DECODE: begin
            sel_on = 1'b1;
            case (ins)
               I_UNK:   last = 1'b1;
               I_JAL:   nxt  = WB;
               default: nxt  = EXEC;
            endcase
         end
         EXEC: begin
            sel_on = 1'b1;
            case (ins)
               I_BEQ, I_JR, I_UNK, I_JAL: last = 1'b1;
               I_LW, I_SW:                nxt  = MEM;
               default:                   nxt  = WB;
            endcase
         end
         MEM: begin
            sel_on = 1'b1;
            if (ins == I_LW) begin
               nxt = WB;
            end else begin
               last   = 1'b1;
               mem_we = (ins == I_SW);
            end
         end
         WB: begin
            sel_on = 1'b1;
            last   = 1'b1;
            reg_we = 1'b1;
         end
         default: nxt = FETCH;
      endcase
      if (reset) begin
         ir_we  = 1'b0;
         reg_we = 1'b0;
         mem_we = 1'b0;
         last   = 1'b0;
         sel_on = 1'b0;
      end
   end

   // Datapath selects, held for the whole instruction from DECODE on.
   always_comb begin
      bus.RegDst   = 2'b00;
      bus.MemtoReg = 2'b00;
      bus.PCSrc    = 2'b00;
      bus.ALUSrc   = 1'b0;
      bus.ExtOp    = 1'b0;
      bus.ALUOp    = 3'b000;
      if (sel_on) begin
         case (ins)
            I_ADD: bus.RegDst = 2'b01;
            I_SUB: begin
               bus.RegDst = 2'b01;
               bus.ALUOp  = 3'b001;
            end
            I_ORI: begin
               bus.ALUSrc = 1'b1;
               bus.ALUOp  = 3'b010;
            end
            I_LUI: begin
               bus.ALUSrc = 1'b1;
               bus.ALUOp  = 3'b011;
            end
            I_LW: begin
               bus.ExtOp    = 1'b1;
               bus.ALUSrc   = 1'b1;
               bus.MemtoReg = 2'b01;
            end
            I_SW: begin
               bus.ExtOp  = 1'b1;
               bus.ALUSrc = 1'b1;
            end
            I_BEQ: begin
               bus.ALUOp = 3'b001;
               bus.ExtOp = 1'b1;
               bus.PCSrc = bus.zero ? 2'b01 : 2'b00;
            end
            I_JAL: begin
               bus.RegDst   = 2'b10;
               bus.MemtoReg = 2'b10;
               bus.PCSrc    = 2'b10;
            end
            I_JR:    bus.PCSrc = 2'b11;
            default: bus.PCSrc = 2'b00;
         endcase
      end
   end

   assign bus.ir_we      = ir_we;
   assign bus.pc_we      = last;
   assign bus.instr_done = last;
   assign bus.reg_we     = reg_we;
   assign bus.mem_we     = mem_we;
   assign bus.state      = cur;

`ifdef MC_PERF_EN
   logic [31:0] cycle_cnt;
   logic [31:0] retire_cnt;

   // Free-running cycle and retired-instruction counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt  <= 32'd0;
         retire_cnt <= 32'd0;
      end else begin
         cycle_cnt  <= cycle_cnt + 32'd1;
         retire_cnt <= retire_cnt + {31'd0, last};
      end
   end

   assign bus.cycle_cnt  = cycle_cnt;
   assign bus.retire_cnt = retire_cnt;
`endif
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: vector table plus random programs against an instruction-level model.
// Two DUTs (FETCH_WAIT 0 and 2) run one at a time while the other sits in reset.
module tb_mc_ctrl;
   localparam int C_ADD = 0, C_SUB = 1, C_JR = 2, C_ORI = 3, C_LUI = 4;
   localparam int C_LW = 5, C_SW = 6, C_BEQ = 7, C_JAL = 8, C_UNK = 9;
   localparam int S_F = 0, S_D = 1, S_E = 2, S_M = 3, S_W = 4;

   logic       clk = 1'b0;
   logic       rst0 = 1'b1;
   logic       rst2 = 1'b1;
   logic [5:0] op_r = '0;
   logic [5:0] func_r = '0;
   logic       zero_r = 1'b0;

   always #5 clk = ~clk;

   mc_ctrl_if if0 ();
   mc_ctrl_if if2 ();

   assign if0.op = op_r;
   assign if0.func = func_r;
   assign if0.zero = zero_r;
   assign if2.op = op_r;
   assign if2.func = func_r;
   assign if2.zero = zero_r;

   mc_ctrl #(.FETCH_WAIT(0)) u0 (.clk(clk), .reset(rst0), .bus(if0.master));
   mc_ctrl #(.FETCH_WAIT(2)) u2 (.clk(clk), .reset(rst2), .bus(if2.master));

   logic [18:0] obs0;
   logic [18:0] obs2;
   assign obs0 = {if0.state, if0.ir_we, if0.pc_we, if0.reg_we, if0.mem_we,
                  if0.RegDst, if0.MemtoReg, if0.PCSrc, if0.ALUSrc, if0.ExtOp,
                  if0.ALUOp, if0.instr_done};
   assign obs2 = {if2.state, if2.ir_we, if2.pc_we, if2.reg_we, if2.mem_we,
                  if2.RegDst, if2.MemtoReg, if2.PCSrc, if2.ALUSrc, if2.ExtOp,
                  if2.ALUOp, if2.instr_done};

   int passed = 0;
   int total = 0;
   int cyc_n = 0;
   int ret_n = 0;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   function automatic int classify(input logic [5:0] o, input logic [5:0] f);
      if (o == 6'h00) begin
         if (f == 6'h20) return C_ADD;
         if (f == 6'h22) return C_SUB;
         if (f == 6'h08) return C_JR;
         return C_UNK;
      end
      case (o)
         6'h0d: return C_ORI;
         6'h0f: return C_LUI;
         6'h23: return C_LW;
         6'h2b: return C_SW;
         6'h04: return C_BEQ;
         6'h03: return C_JAL;
         default: return C_UNK;
      endcase
   endfunction

   // {RegDst, MemtoReg, PCSrc, ALUSrc, ExtOp, ALUOp}
   function automatic logic [10:0] sel_exp(input int c, input logic z);
      case (c)
         C_ADD: return {2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 3'b000};
         C_SUB: return {2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 3'b001};
         C_ORI: return {2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 3'b010};
         C_LUI: return {2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 3'b011};
         C_LW:  return {2'b00, 2'b01, 2'b00, 1'b1, 1'b1, 3'b000};
         C_SW:  return {2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 3'b000};
         C_BEQ: return {2'b00, 2'b00, z ? 2'b01 : 2'b00, 1'b0, 1'b1, 3'b001};
         C_JAL: return {2'b10, 2'b10, 2'b10, 1'b0, 1'b0, 3'b000};
         C_JR:  return {2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 3'b000};
         default: return 11'd0;
      endcase
   endfunction

   function automatic bit writes_reg(input int c);
      return c == C_ADD || c == C_SUB || c == C_ORI || c == C_LUI ||
             c == C_LW || c == C_JAL;
   endfunction

   task automatic set_rst(input bit fw2, input logic v);
      if (fw2) rst2 = v;
      else rst0 = v;
   endtask

   task automatic do_reset(input bit fw2);
      logic [18:0] got;
      set_rst(fw2, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      got = fw2 ? obs2 : obs0;
      chk("reset", 32'(got), 32'd0);
      @(posedge clk); #1;
      set_rst(fw2, 1'b0);
      cyc_n = 0;
      ret_n = 0;
   endtask

   task automatic run_instr(input bit fw2, input logic [5:0] o,
                            input logic [5:0] f, input int zm,
                            input int abort_at, output int ncyc,
                            output int nreg, output int nmem);
      int          seq[$];
      int          fw;
      int          c;
      bit          lst;
      logic [18:0] got;
      logic [18:0] exp;
      logic        z;
      fw = fw2 ? 2 : 0;
      c = classify(o, f);
      for (int k = 0; k <= fw; k++) seq.push_back(S_F);
      seq.push_back(S_D);
      case (c)
         C_LW: begin
            seq.push_back(S_E); seq.push_back(S_M); seq.push_back(S_W);
         end
         C_SW: begin
            seq.push_back(S_E); seq.push_back(S_M);
         end
         C_BEQ, C_JR: seq.push_back(S_E);
         C_JAL: seq.push_back(S_W);
         C_UNK: ;
         default: begin
            seq.push_back(S_E); seq.push_back(S_W);
         end
      endcase
      ncyc = 0;
      nreg = 0;
      nmem = 0;
      for (int i = 0; i < seq.size(); i++) begin
         op_r = (seq[i] == S_F) ? 6'($urandom) : o;
         func_r = (seq[i] == S_F) ? 6'($urandom) : f;
         z = (zm == 2) ? 1'($urandom) : zm[0];
         zero_r = z;
         if (i == abort_at) set_rst(fw2, 1'b1);
         @(negedge clk);
         got = fw2 ? obs2 : obs0;
         if (i == abort_at) begin
            chk("abort", 32'(got), 32'({3'(seq[i]), 16'd0}));
            @(posedge clk); #1;
            set_rst(fw2, 1'b0);
            cyc_n = 0;
            ret_n = 0;
            ncyc = i + 1;
            return;
         end
`ifdef MC_PERF_EN
         if (i == 0) begin
            chk("cycle_cnt", fw2 ? if2.cycle_cnt : if0.cycle_cnt, 32'(cyc_n));
            chk("retire_cnt", fw2 ? if2.retire_cnt : if0.retire_cnt, 32'(ret_n));
         end
`endif
         lst = (i == seq.size() - 1);
         exp = {3'(seq[i]), (i == fw), lst, lst && writes_reg(c),
                lst && (c == C_SW),
                (seq[i] == S_F) ? 11'd0 : sel_exp(c, z), lst};
         chk($sformatf("op%02h_f%02h_c%0d", o, f, i), 32'(got), 32'(exp));
         nreg += int'(got[13]);
         nmem += int'(got[12]);
         ncyc++;
         cyc_n++;
         if (got[0]) ret_n++;
         @(posedge clk); #1;
      end
   endtask

   typedef struct {
      bit         fw2;
      logic [5:0] op;
      logic [5:0] func;
      int         zm;
      int         cyc;
      int         regs;
      int         mems;
   } vec_t;

   vec_t vt[$];
   logic [5:0] lops[9];
   logic [5:0] lfun[9];

   initial begin
      int nc, nr, nm, r;
      logic [5:0] o, f;
      vt.push_back('{0, 6'h00, 6'h20, 0, 4, 1, 0});
      vt.push_back('{0, 6'h00, 6'h22, 1, 4, 1, 0});
      vt.push_back('{0, 6'h0d, 6'h11, 0, 4, 1, 0});
      vt.push_back('{0, 6'h0f, 6'h00, 0, 4, 1, 0});
      vt.push_back('{0, 6'h04, 6'h00, 1, 3, 0, 0});
      vt.push_back('{0, 6'h04, 6'h00, 0, 3, 0, 0});
      vt.push_back('{0, 6'h03, 6'h00, 0, 3, 1, 0});
      vt.push_back('{0, 6'h00, 6'h08, 0, 3, 0, 0});
      vt.push_back('{0, 6'h3f, 6'h3f, 0, 2, 0, 0});
      vt.push_back('{0, 6'h00, 6'h00, 0, 2, 0, 0});
      vt.push_back('{0, 6'h23, 6'h05, 0, 5, 1, 0});
      vt.push_back('{0, 6'h2b, 6'h05, 0, 4, 0, 1});
      vt.push_back('{1, 6'h23, 6'h00, 0, 7, 1, 0});
      vt.push_back('{1, 6'h2b, 6'h00, 0, 6, 0, 1});
      vt.push_back('{1, 6'h00, 6'h20, 0, 6, 1, 0});
      vt.push_back('{1, 6'h04, 6'h00, 1, 5, 0, 0});
      vt.push_back('{1, 6'h11, 6'h00, 0, 4, 0, 0});
      lops = '{6'h00, 6'h00, 6'h00, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h03};
      lfun = '{6'h20, 6'h22, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

      for (int d = 0; d < 2; d++) begin
         rst0 = 1'b1;
         rst2 = 1'b1;
         do_reset(d == 1);
         foreach (vt[i]) begin
            if (vt[i].fw2 == (d == 1)) begin
               run_instr(vt[i].fw2, vt[i].op, vt[i].func, vt[i].zm, -1,
                         nc, nr, nm);
               chk($sformatf("len%0d", i), 32'(nc), 32'(vt[i].cyc));
               chk($sformatf("regs%0d", i), 32'(nr), 32'(vt[i].regs));
               chk($sformatf("mems%0d", i), 32'(nm), 32'(vt[i].mems));
            end
         end
         if (d == 1) begin
            run_instr(1'b1, 6'h2b, 6'h00, 0, 5, nc, nr, nm);
            chk("abort_nomem", 32'(nm), 32'd0);
         end
         for (int n = 0; n < 20; n++) begin
            r = $urandom_range(0, 9);
            if (r == 9) begin
               o = 6'($urandom);
               f = 6'($urandom);
            end else begin
               o = lops[r];
               f = lfun[r];
            end
            run_instr(d == 1, o, f, 2, -1, nc, nr, nm);
            chk("one_write", 32'(nr + nm <= 1), 32'd1);
         end
         run_instr(d == 1, 6'h00, 6'h20, 0, -1, nc, nr, nm);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end
endmodule
